// File: rtl/sico_stream_tap.sv
// Passive valid/ready stream tap feeding the SiCo recorder through a small FIFO.
// Optional drop counter enabled by defining SICO_TAP_DROPCNT_EN.
module sico_stream_tap #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mon_valid_i,
  input  logic                       mon_ready_i,
  input  logic [WIDTH-1:0]           mon_data_i,
  input  logic                       clear_i,
  output logic                       rec_valid_o,
  output logic [WIDTH-1:0]           rec_data_o,
  input  logic                       rec_hold_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
`ifdef SICO_TAP_DROPCNT_EN
  ,
  output logic [CNT_W-1:0]           drop_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;

  logic push, pop, full, drop, wr_en;

  always_comb begin
    push  = mon_valid_i & mon_ready_i;
    pop   = (level_q != '0) & ~rec_hold_i;
    full  = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
    drop  = push & full & ~pop;
    wr_en = push & ~drop;
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: level_q gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= mon_data_i;
    end
  end

`ifdef SICO_TAP_DROPCNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, drop_cnt_base;

  // Clear applies first so a drop in the clearing cycle still counts as one.
  always_comb begin
    drop_cnt_base = clear_i ? '0 : drop_cnt_q;
    drop_cnt_d    = drop_cnt_base;
    if (drop && (drop_cnt_base != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign rec_valid_o = pop;
  assign rec_data_o  = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_sico_stream_tap.sv
// Scoreboard bench for sico_stream_tap: stimulus queues expected beats, a monitor checks drains.
module tb_sico_stream_tap;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       mon_valid_i = 1'b0;
  logic       mon_ready_i = 1'b0;
  logic [7:0] mon_data_i = '0;
  logic       clear_i = 1'b0;
  logic       rec_valid_o;
  logic [7:0] rec_data_o;
  logic       rec_hold_i = 1'b0;
  logic [2:0] level_o;
  logic       overflow_o;
`ifdef SICO_TAP_DROPCNT_EN
  logic [15:0] drop_cnt_o;
`endif

  sico_stream_tap #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mon_valid_i (mon_valid_i),
    .mon_ready_i (mon_ready_i),
    .mon_data_i  (mon_data_i),
    .clear_i     (clear_i),
    .rec_valid_o (rec_valid_o),
    .rec_data_o  (rec_data_o),
    .rec_hold_i  (rec_hold_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
`ifdef SICO_TAP_DROPCNT_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;
  int pop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [7:0] d, input bit exp_push);
    mon_valid_i = v;
    mon_ready_i = r;
    mon_data_i  = d;
    if (exp_push) exp_q.push_back(d);
    step();
  endtask

  task automatic idle(input int n);
    mon_valid_i = 1'b0;
    mon_ready_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every recorder transfer must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni && rec_valid_o) begin
      vectors++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got 0x%0h, expected no transfer", rec_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rec_data_o !== e) begin
          errors++;
          $display("FAIL out_data: got 0x%0h, expected 0x%0h", rec_data_o, e);
        end
      end
    end
  end

  initial begin
    int p0;
    // Reset / idle
    #12;
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_valid", 32'(rec_valid_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step();

    // Basic pass-through with one-cycle latency
    drive(1'b1, 1'b1, 8'h11, 1'b1);
    chk("lat_valid", 32'(rec_valid_o), 32'd1);
    chk("lat_level", 32'(level_o), 32'd1);
    drive(1'b1, 1'b1, 8'h22, 1'b1);
    drive(1'b1, 1'b1, 8'h33, 1'b1);
    chk("pass_level", 32'(level_o), 32'd1);
    idle(3);
    chk("pass_empty", 32'(level_o), 32'd0);

    // Backpressure: fill under hold, then drain on consecutive cycles
    rec_hold_i = 1'b1;
    drive(1'b1, 1'b1, 8'hA1, 1'b1);
    drive(1'b1, 1'b1, 8'hA2, 1'b1);
    drive(1'b1, 1'b1, 8'hA3, 1'b1);
    drive(1'b1, 1'b1, 8'hA4, 1'b1);
    idle(1);
    chk("bp_level", 32'(level_o), 32'd4);
    chk("bp_valid", 32'(rec_valid_o), 32'd0);
    p0 = pop_cnt;
    rec_hold_i = 1'b0;
    idle(4);
    chk("bp_drain_cnt", 32'(pop_cnt - p0), 32'd4);
    chk("bp_drain_level", 32'(level_o), 32'd0);

    // Overflow while full and held
    rec_hold_i = 1'b1;
    drive(1'b1, 1'b1, 8'hB1, 1'b1);
    drive(1'b1, 1'b1, 8'hB2, 1'b1);
    drive(1'b1, 1'b1, 8'hB3, 1'b1);
    drive(1'b1, 1'b1, 8'hB4, 1'b1);
    chk("ovf_pre", 32'(overflow_o), 32'd0);
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_level", 32'(level_o), 32'd4);
`ifdef SICO_TAP_DROPCNT_EN
    chk("ovf_cnt", 32'(drop_cnt_o), 32'd1);
`endif
    mon_valid_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_ovf", 32'(overflow_o), 32'd0);
    chk("clr_level", 32'(level_o), 32'd4);
`ifdef SICO_TAP_DROPCNT_EN
    chk("clr_cnt", 32'(drop_cnt_o), 32'd0);
`endif
    // Clear and drop together: drop wins
    clear_i = 1'b1;
    drive(1'b1, 1'b1, 8'hAB, 1'b0);
    clear_i = 1'b0;
    chk("clr_drop_ovf", 32'(overflow_o), 32'd1);
`ifdef SICO_TAP_DROPCNT_EN
    chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
    mon_valid_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr2_ovf", 32'(overflow_o), 32'd0);
    rec_hold_i = 1'b0;
    idle(5);
    chk("ovf_drained", 32'(level_o), 32'd0);

    // Full with simultaneous push/pop
    rec_hold_i = 1'b1;
    drive(1'b1, 1'b1, 8'hC0, 1'b1);
    drive(1'b1, 1'b1, 8'hC1, 1'b1);
    drive(1'b1, 1'b1, 8'hC2, 1'b1);
    drive(1'b1, 1'b1, 8'hC3, 1'b1);
    rec_hold_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'hC4 + 8'(i), 1'b1);
      chk("full_pp_level", 32'(level_o), 32'd4);
    end
    chk("full_pp_ovf", 32'(overflow_o), 32'd0);
    idle(6);
    chk("full_pp_empty", 32'(level_o), 32'd0);

    // Valid without ready is never captured
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
    idle(1);
    chk("qual_level", 32'(level_o), 32'd0);
    chk("qual_valid", 32'(rec_valid_o), 32'd0);

    // Mid-cycle async reset with level 3 flushes everything
    rec_hold_i = 1'b1;
    drive(1'b1, 1'b1, 8'hD1, 1'b1);
    drive(1'b1, 1'b1, 8'hD2, 1'b1);
    drive(1'b1, 1'b1, 8'hD3, 1'b1);
    mon_valid_i = 1'b0;
    chk("flush_pre", 32'(level_o), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("flush_level", 32'(level_o), 32'd0);
    chk("flush_valid", 32'(rec_valid_o), 32'd0);
    chk("flush_ovf", 32'(overflow_o), 32'd0);
    exp_q.delete();
    step();
    rst_ni = 1'b1;
    rec_hold_i = 1'b0;
    idle(5);
    chk("flush_post_level", 32'(level_o), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
